// File: rtl/a25_wb_mem_responder.sv
// a25_wb_mem_responder
// Wishbone classic slave serving 128-bit line reads and byte-enabled writes
// for the a25 core. A small FSM captures a request, inserts WAIT_CYCLES wait
// states, then terminates with a single-cycle ack (in window) or err (out of
// window). A side-band load port preloads lines, and a write monitor reports
// every committed bus write.
module a25_wb_mem_responder #(
   parameter int          DEPTH       = 256,
   parameter int          WAIT_CYCLES = 2,
   parameter logic [31:0] BASE_ADR    = 32'h0,
   localparam int         AW          = $clog2(DEPTH)
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   // Wishbone classic slave
   input  logic          i_wb_cyc,
   input  logic          i_wb_stb,
   input  logic          i_wb_we,
   input  logic [31:0]   i_wb_adr,
   input  logic [15:0]   i_wb_sel,
   input  logic [127:0]  i_wb_dat,
   output logic [127:0]  o_wb_dat,
   output logic          o_wb_ack,
   output logic          o_wb_err,
   // Side-band preload port
   input  logic          i_load_en,
   input  logic [AW-1:0] i_load_idx,
   input  logic [127:0]  i_load_dat,
   // Status and write monitor
   output logic          o_busy,
   output logic          o_wr_valid,
   output logic [31:0]   o_wr_adr,
   output logic [15:0]   o_wr_sel,
   output logic [127:0]  o_wr_dat
);

   localparam logic [31:0] DEPTH_W = 32'(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   // Line RAM
   logic [127:0] mem [DEPTH];

   // Address decode of the live bus request
   logic [27:0]   off_line;
   logic          dec_in_range;
   logic [AW-1:0] dec_idx;

   // FSM and captured request
   state_t        state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   logic          req_we_q, req_we_d;
   logic [27:0]   req_line_q, req_line_d;
   logic [15:0]   req_sel_q, req_sel_d;
   logic [127:0]  req_dat_q, req_dat_d;
   logic [AW-1:0] req_idx_q, req_idx_d;
   logic          req_in_range_q, req_in_range_d;

   // Registered bus and monitor outputs
   logic          ack_q, ack_d;
   logic          err_q, err_d;
   logic [127:0]  rd_dat_q, rd_dat_d;
   logic          wr_valid_q, wr_valid_d;
   logic [31:0]   wr_adr_q, wr_adr_d;
   logic [15:0]   wr_sel_q, wr_sel_d;
   logic [127:0]  wr_dat_q, wr_dat_d;

   // RAM write controls
   logic          commit;
   logic          load_hit;

   // Decode the bus address into a line offset relative to BASE_ADR.
   // BASE_ADR is line aligned, so subtracting the line fields alone equals
   // the line field of the full 32-bit wrapped difference.
   always_comb begin
      off_line     = i_wb_adr[31:4] - BASE_ADR[31:4];
      dec_in_range = (i_wb_adr >= BASE_ADR) && ({4'b0000, off_line} < DEPTH_W);
      dec_idx      = off_line[AW-1:0];
   end

   // Next-state and next-output logic for the request FSM.
   always_comb begin
      // NOTE: every signal driven here gets a default first, so no path leaves
      // one unassigned and no latch is inferred.
      state_d        = state_q;
      cnt_d          = cnt_q;
      req_we_d       = req_we_q;
      req_line_d     = req_line_q;
      req_sel_d      = req_sel_q;
      req_dat_d      = req_dat_q;
      req_idx_d      = req_idx_q;
      req_in_range_d = req_in_range_q;
      ack_d          = 1'b0;
      err_d          = 1'b0;
      rd_dat_d       = '0;
      wr_valid_d     = 1'b0;
      wr_adr_d       = '0;
      wr_sel_d       = '0;
      wr_dat_d       = '0;

      unique case (state_q)
         S_IDLE: begin
            if (i_wb_cyc && i_wb_stb) begin
               req_we_d       = i_wb_we;
               req_line_d     = i_wb_adr[31:4];
               req_sel_d      = i_wb_sel;
               req_dat_d      = i_wb_dat;
               req_idx_d      = dec_idx;
               req_in_range_d = dec_in_range;
               if (WAIT_CYCLES == 0) begin
                  state_d = S_RESP;
               end else begin
                  state_d = S_WAIT;
                  cnt_d   = 4'(WAIT_CYCLES - 1);
               end
            end
         end
         S_WAIT: begin
            if (!i_wb_cyc) begin
               // Master abandoned the cycle: drop the request silently.
               state_d = S_IDLE;
            end else if (cnt_q == 4'd0) begin
               state_d = S_RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_RESP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Termination outputs are registered on entry to RESP, using the request
      // as it will be held there (fresh inputs from IDLE, latched from WAIT).
      // Read data is sampled from the RAM at this same edge, so a load landing
      // on that edge is not yet visible to the read.
      if ((state_q != S_RESP) && (state_d == S_RESP)) begin
         if (req_in_range_d) begin
            ack_d = 1'b1;
            if (req_we_d) begin
               wr_valid_d = 1'b1;
               wr_adr_d   = {req_line_d, 4'h0};
               wr_sel_d   = req_sel_d;
               wr_dat_d   = req_dat_d;
            end else begin
               rd_dat_d = mem[req_idx_d];
            end
         end else begin
            err_d = 1'b1;
         end
      end
   end

   // State and output registers; reset discards any request in flight.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q        <= S_IDLE;
         cnt_q          <= 4'd0;
         req_we_q       <= 1'b0;
         req_line_q     <= '0;
         req_sel_q      <= '0;
         req_dat_q      <= '0;
         req_idx_q      <= '0;
         req_in_range_q <= 1'b0;
         ack_q          <= 1'b0;
         err_q          <= 1'b0;
         rd_dat_q       <= '0;
         wr_valid_q     <= 1'b0;
         wr_adr_q       <= '0;
         wr_sel_q       <= '0;
         wr_dat_q       <= '0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values
         // and the order of statements inside this block does not matter.
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         req_we_q       <= req_we_d;
         req_line_q     <= req_line_d;
         req_sel_q      <= req_sel_d;
         req_dat_q      <= req_dat_d;
         req_idx_q      <= req_idx_d;
         req_in_range_q <= req_in_range_d;
         ack_q          <= ack_d;
         err_q          <= err_d;
         rd_dat_q       <= rd_dat_d;
         wr_valid_q     <= wr_valid_d;
         wr_adr_q       <= wr_adr_d;
         wr_sel_q       <= wr_sel_d;
         wr_dat_q       <= wr_dat_d;
      end
   end

   // A bus write lands at the edge that closes RESP. Because state_q is
   // cleared asynchronously, a reset during RESP suppresses the commit.
   always_comb begin
      commit   = (state_q == S_RESP) && req_we_q && req_in_range_q;
      load_hit = i_load_en && (i_load_idx == req_idx_q);
   end

   // Line RAM write port: byte-enabled bus commit, then full-line preload.
   // A preload to the same line on the same edge wins over the bus write.
   always_ff @(posedge i_clk) begin
      // NOTE: the RAM has no reset; its contents are defined only by writes
      // and preloads, which keeps it mappable onto plain memory macros.
      for (int b = 0; b < 16; b++) begin
         if (commit && !load_hit && req_sel_q[b]) begin
            mem[req_idx_q][8*b +: 8] <= req_dat_q[8*b +: 8];
         end
      end
      if (i_load_en) begin
         mem[i_load_idx] <= i_load_dat;
      end
   end

   assign o_wb_ack   = ack_q;
   assign o_wb_err   = err_q;
   assign o_wb_dat   = rd_dat_q;
   assign o_busy     = (state_q != S_IDLE);
   assign o_wr_valid = wr_valid_q;
   assign o_wr_adr   = wr_adr_q;
   assign o_wr_sel   = wr_sel_q;
   assign o_wr_dat   = wr_dat_q;

endmodule

// File: tb/tb_a25_wb_mem_responder.sv
// Testbench for a25_wb_mem_responder: one instance with two wait states for
// most scenarios and one with zero wait states for back-to-back reads.
// Expected terminations and write reports are queued when a request is
// driven and popped by monitors when the DUT answers.
module tb_a25_wb_mem_responder;

   localparam int WAITS = 2;
   localparam int AW    = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          cyc = 1'b0, stb = 1'b0, we = 1'b0;
   logic          cyc0 = 1'b0, stb0 = 1'b0;
   logic [31:0]   adr = '0;
   logic [15:0]   sel = '0;
   logic [127:0]  dat = '0;
   logic          load_en = 1'b0;
   logic [AW-1:0] load_idx = '0;
   logic [127:0]  load_dat = '0;

   logic [127:0]  rdat, rdat0;
   logic          ack, err, busy, ack0, err0, busy0;
   logic          wr_valid, wr_valid0;
   logic [31:0]   wr_adr, wr_adr0;
   logic [15:0]   wr_sel, wr_sel0;
   logic [127:0]  wr_dat, wr_dat0;

   a25_wb_mem_responder #(.DEPTH(256), .WAIT_CYCLES(WAITS), .BASE_ADR(32'h0)) dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we), .i_wb_adr(adr),
      .i_wb_sel(sel), .i_wb_dat(dat), .o_wb_dat(rdat), .o_wb_ack(ack), .o_wb_err(err),
      .i_load_en(load_en), .i_load_idx(load_idx), .i_load_dat(load_dat),
      .o_busy(busy), .o_wr_valid(wr_valid), .o_wr_adr(wr_adr), .o_wr_sel(wr_sel),
      .o_wr_dat(wr_dat)
   );

   a25_wb_mem_responder #(.DEPTH(256), .WAIT_CYCLES(0), .BASE_ADR(32'h0)) dut0 (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_wb_cyc(cyc0), .i_wb_stb(stb0), .i_wb_we(we), .i_wb_adr(adr),
      .i_wb_sel(sel), .i_wb_dat(dat), .o_wb_dat(rdat0), .o_wb_ack(ack0), .o_wb_err(err0),
      .i_load_en(load_en), .i_load_idx(load_idx), .i_load_dat(load_dat),
      .o_busy(busy0), .o_wr_valid(wr_valid0), .o_wr_adr(wr_adr0), .o_wr_sel(wr_sel0),
      .o_wr_dat(wr_dat0)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic         err;
      logic         chk_dat;
      logic [127:0] dat;
      int           id;
   } rsp_t;

   typedef struct {
      logic [31:0]  adr;
      logic [15:0]  sel;
      logic [127:0] dat;
   } wr_t;

   rsp_t         rsp_q[$];
   wr_t          wr_q[$];
   logic [127:0] model [256];
   int           n_pass = 0;
   int           n_total = 0;
   int           next_id = 0;
   logic         mon_off = 1'b0;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   function automatic logic [127:0] merge(input logic [127:0] old, input logic [127:0] d,
                                          input logic [15:0] s);
      logic [127:0] r;
      r = old;
      for (int b = 0; b < 16; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
      return r;
   endfunction

   // Response and write-report monitor for the wait-state instance.
   always @(negedge clk) begin : mon
      rsp_t e;
      wr_t  w;
      if (rst_n && !mon_off) begin
         if (!ack) check("dat_zero_no_ack", rdat, '0);
         if (ack || err) begin
            if (rsp_q.size() == 0) begin
               check("unexpected_termination", 1'b1, 1'b0);
            end else begin
               e = rsp_q.pop_front();
               check($sformatf("rsp%0d_ack", e.id), ack, !e.err);
               check($sformatf("rsp%0d_err", e.id), err, e.err);
               if (e.chk_dat) check($sformatf("rsp%0d_dat", e.id), rdat, e.dat);
            end
         end
         if (wr_valid) begin
            if (wr_q.size() == 0) begin
               check("unexpected_wr_valid", 1'b1, 1'b0);
            end else begin
               w = wr_q.pop_front();
               check("wr_adr", wr_adr, w.adr);
               check("wr_sel", wr_sel, w.sel);
               check("wr_dat", wr_dat, w.dat);
            end
         end
      end
   end

   task automatic push_rsp(input logic is_err, input logic chk, input logic [127:0] d);
      rsp_t e;
      e.err = is_err; e.chk_dat = chk; e.dat = d; e.id = next_id++;
      rsp_q.push_back(e);
   endtask

   task automatic push_wr(input logic [31:0] a, input logic [15:0] s, input logic [127:0] d);
      wr_t w;
      w.adr = {a[31:4], 4'h0}; w.sel = s; w.dat = d;
      wr_q.push_back(w);
   endtask

   task automatic load_line(input int idx, input logic [127:0] d);
      @(posedge clk); #1;
      load_en = 1'b1; load_idx = AW'(idx); load_dat = d;
      @(posedge clk); #1;
      load_en = 1'b0;
      model[idx] = d;
   endtask

   task automatic drive(input logic we_i, input logic [31:0] a, input logic [15:0] s,
                        input logic [127:0] d);
      @(posedge clk); #1;
      cyc = 1'b1; stb = 1'b1; we = we_i; adr = a; sel = s; dat = d;
   endtask

   // Bounded wait for ack/err on the wait-state instance; returns negedges seen.
   task automatic wait_term(output int k);
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!(ack || err) && k < 20);
   endtask

   task automatic release_bus();
      @(posedge clk); #1;
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
   endtask

   // Full access with scoreboard expectations and latency check.
   task automatic bus_req(input logic we_i, input logic [31:0] a, input logic [15:0] s,
                          input logic [127:0] d, input logic exp_err);
      int k;
      push_rsp(exp_err, !we_i, exp_err ? 128'h0 : model[a[11:4]]);
      if (we_i && !exp_err) begin
         push_wr(a, s, d);
         model[a[11:4]] = merge(model[a[11:4]], d, s);
      end
      drive(we_i, a, s, d);
      wait_term(k);
      check($sformatf("latency_%h", a), 32'(k), 32'(WAITS + 2));
      release_bus();
   endtask

   initial begin
      int k;
      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_ack", ack, 1'b0);
      check("rst_err", err, 1'b0);
      check("rst_dat", rdat, '0);
      check("rst_busy", busy, 1'b0);
      check("rst_wr_valid", wr_valid, 1'b0);
      check("rst_wr_adr", wr_adr, '0);
      check("rst_wr_sel", wr_sel, '0);
      check("rst_wr_dat", wr_dat, '0);
      @(negedge clk); rst_n = 1'b1;

      // Preload
      load_line(0, 128'h00000000_11111111_22222222_33333333);
      load_line(1, 128'hA5A5A5A5_5A5A5A5A_DEADBEEF_CAFEF00D);
      load_line(2, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
      load_line(3, 128'hF0801003_F0801003_F0801003_E0801002);
      load_line(4, 128'h44444444_44444444_44444444_44444444);
      load_line(5, 128'h55555555_55555555_55555555_55555555);
      load_line(6, 128'h66666666_66666666_66666666_66666666);
      load_line(7, 128'h77777777_77777777_77777777_77777777);
      load_line(255, 128'hFFEEDDCC_BBAA9988_77665544_33221100);

      // T4: zero-wait instance, strobe held across four reads
      @(posedge clk); #1;
      cyc0 = 1'b1; stb0 = 1'b1; we = 1'b0; adr = 32'h0;
      for (int i = 0; i < 4; i++) begin
         k = 0;
         do begin
            @(negedge clk);
            k++;
         end while (!ack0 && k < 10);
         check($sformatf("t4_gap%0d", i), 32'(k), 32'd2);
         check($sformatf("t4_dat%0d", i), rdat0, model[i]);
         #1;
         if (i < 3) adr = 32'((i + 1) * 16);
         else begin cyc0 = 1'b0; stb0 = 1'b0; end
      end
      repeat (2) @(negedge clk);
      check("t4_busy_after", busy0, 1'b0);

      // T1: read line 3
      bus_req(1'b0, 32'h30, 16'hFFFF, '0, 1'b0);

      // T2: partial write to line 1, then read back
      bus_req(1'b1, 32'h10, 16'h000F, 128'h5, 1'b0);
      bus_req(1'b0, 32'h10, 16'h0000, '0, 1'b0);
      // Write with no byte enables: acked and reported, RAM unchanged
      bus_req(1'b1, 32'h4C, 16'h0000, 128'h1234, 1'b0);
      bus_req(1'b0, 32'h40, 16'h0000, '0, 1'b0);
      // Full-line write then read
      bus_req(1'b1, 32'h00, 16'hFFFF, 128'hCAFE0000_BEEF1111_D00D2222_F00D3333, 1'b0);
      bus_req(1'b0, 32'h00, 16'h0000, '0, 1'b0);

      // T3: window boundary
      bus_req(1'b0, 32'hFF0, 16'h0000, '0, 1'b0);
      bus_req(1'b0, 32'h1000, 16'h0000, '0, 1'b1);
      bus_req(1'b1, 32'h1000, 16'hFFFF, 128'h99, 1'b1);
      bus_req(1'b0, 32'hFFFF_FFF0, 16'h0000, '0, 1'b1);
      bus_req(1'b0, 32'h00, 16'h0000, '0, 1'b0);

      // T5: abort a write during WAIT
      drive(1'b1, 32'h20, 16'hFFFF, 128'hBAD);
      repeat (2) @(negedge clk);
      check("t5_busy_in_wait", busy, 1'b1);
      #1; cyc = 1'b0; stb = 1'b0;
      @(negedge clk);
      check("t5_busy_after_abort", busy, 1'b0);
      check("t5_no_ack", ack, 1'b0);
      repeat (3) @(negedge clk);
      bus_req(1'b0, 32'h20, 16'h0000, '0, 1'b0);

      // Read of a line preloaded on the RESP-entry edge returns old data
      push_rsp(1'b0, 1'b1, model[7]);
      drive(1'b0, 32'h70, 16'h0000, '0);
      repeat (3) @(negedge clk);
      #1; load_en = 1'b1; load_idx = 8'd7; load_dat = 128'h7A7A_0000_7A7A_0000_7A7A_0000_7A7A_0000;
      @(posedge clk); #1; load_en = 1'b0;
      model[7] = 128'h7A7A_0000_7A7A_0000_7A7A_0000_7A7A_0000;
      wait_term(k);
      check("t_rdload_term", 32'(k), 32'd1);
      release_bus();
      bus_req(1'b0, 32'h70, 16'h0000, '0, 1'b0);

      // T6: reset during WAIT
      drive(1'b0, 32'h30, 16'h0000, '0);
      repeat (2) @(negedge clk);
      check("t6_busy_in_wait", busy, 1'b1);
      #1; rst_n = 1'b0; cyc = 1'b0; stb = 1'b0;
      #1;
      check("t6_rst_busy", busy, 1'b0);
      check("t6_rst_ack", ack, 1'b0);
      check("t6_rst_err", err, 1'b0);
      @(posedge clk); #1; rst_n = 1'b1;
      bus_req(1'b0, 32'h30, 16'h0000, '0, 1'b0);

      // Reset during RESP of a write: no commit
      mon_off = 1'b1;
      drive(1'b1, 32'h60, 16'hFFFF, 128'hDEAD_DEAD);
      wait_term(k);
      check("t6_resp_reached", ack, 1'b1);
      #1; rst_n = 1'b0; cyc = 1'b0; stb = 1'b0;
      #1;
      check("t6_resp_rst_ack", ack, 1'b0);
      check("t6_resp_rst_wr_valid", wr_valid, 1'b0);
      @(posedge clk); #1; rst_n = 1'b1; mon_off = 1'b0;
      bus_req(1'b0, 32'h60, 16'h0000, '0, 1'b0);

      // Same-edge preload and bus write commit to line 5: preload wins
      push_rsp(1'b0, 1'b0, '0);
      push_wr(32'h50, 16'hFFFF, 128'hB0B0B0B0_B0B0B0B0_B0B0B0B0_B0B0B0B0);
      drive(1'b1, 32'h50, 16'hFFFF, 128'hB0B0B0B0_B0B0B0B0_B0B0B0B0_B0B0B0B0);
      wait_term(k);
      check("t6_conflict_latency", 32'(k), 32'(WAITS + 2));
      #1; load_en = 1'b1; load_idx = 8'd5; load_dat = 128'h1D1D1D1D_2E2E2E2E_3F3F3F3F_4A4A4A4A;
      @(posedge clk); #1; load_en = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
      model[5] = 128'h1D1D1D1D_2E2E2E2E_3F3F3F3F_4A4A4A4A;
      bus_req(1'b0, 32'h50, 16'h0000, '0, 1'b0);

      // Drain
      repeat (5) @(negedge clk);
      check("rsp_queue_empty", 32'(rsp_q.size()), 32'd0);
      check("wr_queue_empty", 32'(wr_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
